// File: rtl/oam_dma_master_pkg.sv
// Shared constants and state encoding for the OAM DMA engine.
// Addresses mirror the DMG memory map: OAM at 0xFE00, DMA trigger register at 0xFF46.
package oam_dma_master_pkg;

    localparam logic [15:0] OAM_LOC      = 16'hFE00;
    localparam int unsigned OAM_SIZE     = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_REQ,
        DMA_READ,
        DMA_LATCH,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_master.sv
// OAM DMA engine: on a write to the DMA register, copies XFER_LEN bytes from a source page
// into OAM as one read then one write per byte, mastering the shared bus via req/gnt.
module oam_dma_master
    import oam_dma_master_pkg::*;
#(
    parameter int unsigned          ADDR_SIZE = 16,
    parameter int unsigned          DATA_SIZE = 8,
    parameter int unsigned          XFER_LEN  = OAM_SIZE,
    parameter logic [ADDR_SIZE-1:0] DST_BASE  = OAM_LOC,
    parameter logic [ADDR_SIZE-1:0] REG_ADDR  = DMA_REG_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] reg_addr,
    input  logic                 reg_wr,
    input  logic                 reg_rd,
    input  logic [DATA_SIZE-1:0] reg_wdata,
    output logic [DATA_SIZE-1:0] reg_rdata,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [ADDR_SIZE-1:0] bus_addr,
    output logic                 bus_rd,
    output logic                 bus_wr,
    output logic [DATA_SIZE-1:0] bus_wdata,
    input  logic [DATA_SIZE-1:0] bus_rdata,
    output logic                 busy
);

    localparam logic [7:0]           LAST_IDX    = 8'(XFER_LEN - 1);
    localparam logic [DATA_SIZE-1:0] ECHO_START  = DATA_SIZE'(8'hE0);
    localparam logic [DATA_SIZE-1:0] ECHO_OFFSET = DATA_SIZE'(8'h20);

    dma_state_t           state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic [DATA_SIZE-1:0] src_q, src_d;
    logic [DATA_SIZE-1:0] byte_q, byte_d;
    logic [DATA_SIZE-1:0] page;
    logic [ADDR_SIZE-1:0] rd_addr, wr_addr;
    logic                 trigger;

    assign trigger = reg_wr && (reg_addr == REG_ADDR);

    // Pages 0xE0 and up are the echo-RAM mirror of work RAM.
    assign page    = (src_q >= ECHO_START) ? src_q - ECHO_OFFSET : src_q;
    assign rd_addr = ADDR_SIZE'({page, 8'h00}) + ADDR_SIZE'(idx_q);
    assign wr_addr = DST_BASE + ADDR_SIZE'(idx_q);

    assign busy    = (state_q != DMA_IDLE);
    assign bus_req = busy;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        src_d     = src_q;
        byte_d    = byte_q;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;

        // Without a grant every active state holds, so strobes reissue when gnt returns.
        unique case (state_q)
            DMA_IDLE: ;
            DMA_REQ: begin
                if (bus_gnt) state_d = DMA_READ;
            end
            DMA_READ: begin
                if (bus_gnt) begin
                    bus_rd   = 1'b1;
                    bus_addr = rd_addr;
                    state_d  = DMA_LATCH;
                end
            end
            DMA_LATCH: begin
                if (bus_gnt) begin
                    byte_d  = bus_rdata;
                    state_d = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (bus_gnt) begin
                    bus_wr    = 1'b1;
                    bus_addr  = wr_addr;
                    bus_wdata = byte_q;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DMA_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = DMA_READ;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase

        // A trigger restarts from byte 0; a write strobed this cycle still lands.
        if (trigger) begin
            src_d   = reg_wdata;
            idx_d   = '0;
            state_d = DMA_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            idx_q     <= '0;
            src_q     <= '0;
            byte_q    <= '0;
            reg_rdata <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            byte_q  <= byte_d;
            if (reg_rd && (reg_addr == REG_ADDR)) reg_rdata <= src_q;
        end
    end

endmodule

// File: tb/tb_oam_dma_master.sv
// Self-checking bench for oam_dma_master: memory model with 1-cycle read latency, grant stub,
// and a reference copy model derived from page arithmetic.
module tb_oam_dma_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        busy;

    always #5 clk = ~clk;

    oam_dma_master dut (
        .clk       (clk),
        .reset     (reset),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus_rd) bus_rdata <= mem[bus_addr];
        if (bus_wr) mem[bus_addr] <= bus_wdata;
    end

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt, low_cnt, viol_cnt;
    int          req_bad = 0;
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  exp_oam [160];
    logic [7:0]  old_oam [160];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && !bus_gnt) low_cnt++;
        if (!bus_gnt && (bus_rd || bus_wr)) viol_cnt++;
        if (bus_req !== busy) req_bad++;
        if (bus_rd) rd_q.push_back(bus_addr);
        if (bus_wr) wr_q.push_back(bus_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_page(input logic [7:0] p);
        return (p >= 8'd224) ? p - 8'd32 : p;
    endfunction

    task automatic trigger(input logic [7:0] p);
        reg_addr  = 16'hFF46;
        reg_wdata = p;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
        reg_addr  = 16'h0000;
    endtask

    task automatic reg_read(input logic [15:0] a);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        reg_addr = 16'h0000;
    endtask

    task automatic clear_mon();
        busy_cnt = 0;
        low_cnt  = 0;
        viol_cnt = 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic fill_random(input logic [7:0] p);
        for (int i = 0; i < 256; i++) mem[{p, 8'h00} + 16'(i)] <= 8'($urandom);
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] <= 8'($urandom);
        tick();
    endtask

    task automatic load_expected(input logic [7:0] p);
        for (int i = 0; i < 160; i++) exp_oam[i] = mem[{model_page(p), 8'h00} + 16'(i)];
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 3000 && wr_q.size() < n; k++) tick();
        check("wait_writes", 32'(wr_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input bit rand_gnt);
        int k = 0;
        while (busy && k < 20000) begin
            if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        bus_gnt = 1'b1;
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic check_oam(input string tag);
        int bad = 0;
        for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_seq(input string tag, input logic [15:0] rbase);
        int bad = 0;
        check({tag, "_nrd"}, rd_q.size(), 160);
        check({tag, "_nwr"}, wr_q.size(), 160);
        for (int i = 0; i < 160 && i < rd_q.size(); i++) if (rd_q[i] !== rbase + 16'(i)) bad++;
        for (int i = 0; i < 160 && i < wr_q.size(); i++) if (wr_q[i] !== 16'hFE00 + 16'(i)) bad++;
        check({tag, "_addrs"}, bad, 0);
    endtask

    initial begin
        logic [7:0] p;
        logic [7:0] q;
        reset     = 1'b1;
        reg_addr  = 16'h0000;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_wdata = 8'h00;
        bus_gnt   = 1'b1;
        clear_mon();
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(bus_req), 0);
        check("rst_rd", 32'(bus_rd), 0);
        check("rst_wr", 32'(bus_wr), 0);
        check("rst_addr", 32'(bus_addr), 0);
        check("rst_wdata", 32'(bus_wdata), 0);
        check("rst_rdata", 32'(reg_rdata), 0);
        reset = 1'b0;
        tick();

        // Known pattern from page 0xC1, grant held high.
        for (int i = 0; i < 256; i++) mem[16'hC100 + 16'(i)] <= 8'(i) ^ 8'h5A;
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] <= 8'($urandom);
        tick();
        for (int i = 0; i < 160; i++) exp_oam[i] = 8'(i) ^ 8'h5A;
        clear_mon();
        trigger(8'hC1);
        check("t1_busy_next", 32'(busy), 1);
        wait_idle(1'b0);
        check("t1_busy_cycles", busy_cnt, 481);
        check_oam("t1_oam");
        check_seq("t1", 16'hC100);

        // Echo-RAM source page.
        fill_random(8'hC3);
        load_expected(8'hE3);
        clear_mon();
        trigger(8'hE3);
        wait_idle(1'b0);
        check_seq("t2", 16'hC300);
        check_oam("t2_oam");
        reg_read(16'hFF46);
        check("t2_rdata", 32'(reg_rdata), 32'hE3);

        // Writes to other registers are ignored.
        reg_addr  = 16'hFF45;
        reg_wdata = 8'h77;
        reg_wr    = 1'b1;
        tick();
        reg_wr = 1'b0;
        repeat (3) tick();
        check("t6_busy", 32'(busy), 0);
        reg_read(16'hFF45);
        check("t6_rdata_other", 32'(reg_rdata), 32'hE3);
        reg_read(16'hFF46);
        check("t6_rdata", 32'(reg_rdata), 32'hE3);

        // Grant dropped for 10 cycles at byte 37.
        p = 8'($urandom_range(8'hC4, 8'hDD));
        fill_random(p);
        if ($urandom_range(0, 1) == 1) p = p + 8'h20;
        load_expected(p);
        clear_mon();
        trigger(p);
        wait_writes(37);
        bus_gnt = 1'b0;
        repeat (10) tick();
        bus_gnt = 1'b1;
        wait_idle(1'b0);
        check("t3_viol", viol_cnt, 0);
        check("t3_busy_cycles", busy_cnt, 491);
        check_oam("t3_oam");
        check_seq("t3", {model_page(p), 8'h00});

        // Retrigger with page 0xC2 at byte 80.
        fill_random(8'hC5);
        for (int i = 0; i < 256; i++) mem[16'hC200 + 16'(i)] <= 8'($urandom);
        tick();
        load_expected(8'hC2);
        clear_mon();
        trigger(8'hC5);
        wait_writes(80);
        trigger(8'hC2);
        clear_mon();
        wait_idle(1'b0);
        check_oam("t4_oam");
        check_seq("t4", 16'hC200);

        // Retrigger landing on the final write of a transfer.
        p = 8'($urandom_range(8'hC4, 8'hCF));
        q = 8'($urandom_range(8'hD0, 8'hDD));
        for (int i = 0; i < 256; i++) mem[{q, 8'h00} + 16'(i)] <= 8'($urandom);
        fill_random(p);
        load_expected(p);
        clear_mon();
        trigger(p);
        wait_writes(159);
        tick();
        tick();
        trigger(q);
        check("coinc_nwr", wr_q.size(), 160);
        check("coinc_busy", 32'(busy), 1);
        check_oam("coinc_old_oam");
        load_expected(q);
        clear_mon();
        wait_idle(1'b0);
        check_oam("coinc_new_oam");
        check_seq("coinc", {q, 8'h00});

        // Random grant pattern: every ungranted busy cycle stretches the transfer by one.
        p = 8'($urandom_range(8'hC4, 8'hDD));
        fill_random(p);
        p = p + 8'h20;
        load_expected(p);
        clear_mon();
        trigger(p);
        wait_idle(1'b1);
        check("rg_viol", viol_cnt, 0);
        check("rg_busy_cycles", busy_cnt, 481 + low_cnt);
        check_oam("rg_oam");
        check_seq("rg", {model_page(p), 8'h00});

        // Reset at byte 50 aborts immediately.
        p = 8'($urandom_range(8'hC4, 8'hDD));
        fill_random(p);
        load_expected(p);
        for (int i = 0; i < 160; i++) old_oam[i] = mem[16'hFE00 + 16'(i)];
        clear_mon();
        trigger(p);
        wait_writes(50);
        reset = 1'b1;
        tick();
        check("t5_busy", 32'(busy), 0);
        check("t5_req", 32'(bus_req), 0);
        check("t5_rd", 32'(bus_rd), 0);
        check("t5_wr", 32'(bus_wr), 0);
        reset = 1'b0;
        repeat (5) tick();
        check("t5_nwr", wr_q.size(), 50);
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) bad++;
            for (int i = 50; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== old_oam[i]) bad++;
            check("t5_oam", bad, 0);
        end
        check("req_tracks_busy", req_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
